arm_barrel_shifter: RTL

Two-stage pipelined 32-bit barrel shifter that produces the ALU's B operand (`bus_B`) and the shifter carry-out. It sits directly upstream of the 32-bit ALU, between the register-bank read port and ALU input B. It implements ARM data-processing operand-2 semantics: LSL/LSR/ASR/ROR/RRX, with immediate or register-specified amounts. A valid/ready handshake on both sides absorbs ALU stalls without losing operands.

---
 rtl/arm_barrel_shifter.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/arm_barrel_shifter.sv
// ---------------------------------------------------------------------------
// arm_barrel_shifter
//   Two-stage pipelined barrel shifter that produces the ALU B operand and the
//   shifter carry-out with ARM operand-2 semantics (LSL/LSR/ASR/ROR/RRX,
//   immediate or register-specified amount). A valid/ready handshake on both
//   sides lets the pipe absorb ALU stalls without dropping operands.
//
//   Stage 1 normalizes the amount into eff (0..33, 33 = "more than 32") and a
//   special-case code. Stage 2 runs a 5-level log shifter, applies the
//   boundary/special overrides and registers the result.
//
//   Optional feature macro: ARM_SHIFTER_RRX_EN
//     defined   : immediate ROR #0 performs RRX
//     undefined : immediate ROR #0 is a pass-through with carry = carry_in
//
// Ports
//   clk           in   clock, rising edge
//   reset         in   asynchronous active-high reset
//   in_valid      in   operand/controls valid
//   in_ready      out  shifter can accept an operand
//   operand       in   value to shift (Rm)
//   shift_type    in   00 LSL, 01 LSR, 10 ASR, 11 ROR
//   shift_amount  in   register amount [7:0], or immediate amount [4:0]
//   amount_is_reg in   1 = register-specified amount
//   carry_in      in   current C flag
//   out_valid     out  bus_B / shifter_carry valid
//   out_ready     in   ALU consumes the result
//   bus_B         out  shifted operand
//   shifter_carry out  shifter carry-out
// ---------------------------------------------------------------------------
module arm_barrel_shifter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand,
    input  logic [1:0]       shift_type,
    input  logic [7:0]       shift_amount,
    input  logic             amount_is_reg,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bus_B,
    output logic             shifter_carry
);

    localparam int unsigned EFF_W   = 6;
    localparam int unsigned LEVELS  = 5;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam logic [EFF_W-1:0] EFF_32   = EFF_W'(32);
    localparam logic [EFF_W-1:0] EFF_OVER = EFF_W'(33);

`ifdef ARM_SHIFTER_RRX_EN
    typedef enum logic [1:0] {
        SP_NONE  = 2'd0,
        SP_IMM32 = 2'd1,
        SP_RRX   = 2'd2
    } special_t;
`else
    typedef enum logic [1:0] {
        SP_NONE  = 2'd0,
        SP_IMM32 = 2'd1
    } special_t;
`endif

    // Pipeline state
    logic             s1_valid;
    logic [WIDTH-1:0] s1_op;
    logic             s1_carry;
    logic [1:0]       s1_type;
    logic [EFF_W-1:0] s1_eff;
    special_t         s1_special;
    logic             s2_valid;

    // Handshake
    logic s2_adv;
    logic s1_adv;
    logic accept;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = s1_valid && s2_adv;
    assign in_ready  = !reset && (!s1_valid || s2_adv);
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;

    // Stage 1: fold immediate/register encodings into eff + special code
    logic [EFF_W-1:0] n_eff;
    special_t         n_special;

    always_comb begin
        n_eff     = '0;
        n_special = SP_NONE;
        if (amount_is_reg) begin
            if (shift_type == SH_ROR) begin
                // Rotation only cares about n[4:0]; a non-zero multiple of 32
                // is encoded as eff = 32 (value unchanged, carry = bit 31).
                if (shift_amount == 8'd0) begin
                    n_eff = '0;
                end else if (shift_amount[4:0] == 5'd0) begin
                    n_eff = EFF_32;
                end else begin
                    n_eff = EFF_W'(shift_amount[4:0]);
                end
            end else if (shift_amount > 8'd32) begin
                n_eff = EFF_OVER;
            end else begin
                n_eff = shift_amount[EFF_W-1:0];
            end
        end else begin
            n_eff = EFF_W'(shift_amount[4:0]);
            if (shift_amount[4:0] == 5'd0) begin
                case (shift_type)
                    SH_LSR, SH_ASR: begin
                        n_eff     = EFF_32;
                        n_special = SP_IMM32;
                    end
`ifdef ARM_SHIFTER_RRX_EN
                    SH_ROR: n_special = SP_RRX;
`endif
                    default: n_special = SP_NONE;
                endcase
            end
        end
    end

    // One level of the log shifter
    function automatic logic [WIDTH-1:0] shift_stage(
        input logic [WIDTH-1:0] v,
        input logic [1:0]       t,
        input int unsigned      s
    );
        logic [WIDTH-1:0] r;
        case (t)
            SH_LSL:  r = v << s;
            SH_LSR:  r = v >> s;
            SH_ASR:  r = WIDTH'($signed(v) >>> s);
            default: r = (v >> s) | (v << (WIDTH - s));
        endcase
        return r;
    endfunction

    // Stage 2: 5-level shifter (16/8/4/2/1) plus boundary and special overrides
    logic [WIDTH-1:0] lvl;
    logic [WIDTH-1:0] sign_fill;
    logic [4:0]       n5;
    logic [WIDTH-1:0] res;
    logic             cout;

    always_comb begin
        lvl = s1_op;
        for (int i = LEVELS - 1; i >= 0; i--) begin
            if (s1_eff[i]) begin
                lvl = shift_stage(lvl, s1_type, 32'd1 << i);
            end
        end

        n5        = s1_eff[4:0];
        sign_fill = {WIDTH{s1_op[WIDTH-1]}};
        res       = lvl;
        cout      = s1_carry;

        if (s1_eff == '0) begin
            res  = s1_op;
            cout = s1_carry;
        end else if (s1_eff < EFF_32) begin
            case (s1_type)
                SH_LSL:  cout = s1_op[5'd0 - n5];       // bit 32-n
                SH_LSR,
                SH_ASR:  cout = s1_op[n5 - 5'd1];       // bit n-1
                default: cout = lvl[WIDTH-1];
            endcase
        end else if (s1_eff == EFF_32) begin
            case (s1_type)
                SH_LSL:  begin res = '0;        cout = s1_op[0];       end
                SH_LSR:  begin res = '0;        cout = s1_op[WIDTH-1]; end
                SH_ASR:  begin res = sign_fill; cout = s1_op[WIDTH-1]; end
                default: begin res = s1_op;     cout = s1_op[WIDTH-1]; end
            endcase
        end else begin
            case (s1_type)
                SH_ASR:  begin res = sign_fill; cout = s1_op[WIDTH-1]; end
                SH_ROR:  begin res = s1_op;     cout = s1_op[WIDTH-1]; end
                default: begin res = '0;        cout = 1'b0;           end
            endcase
        end

        case (s1_special)
            SP_IMM32: begin
                res  = (s1_type == SH_ASR) ? sign_fill : '0;
                cout = s1_op[WIDTH-1];
            end
`ifdef ARM_SHIFTER_RRX_EN
            SP_RRX: begin
                res  = {s1_carry, s1_op[WIDTH-1:1]};
                cout = s1_op[0];
            end
`endif
            default: ;
        endcase
    end

    // Pipeline registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid      <= 1'b0;
            s1_op         <= '0;
            s1_carry      <= 1'b0;
            s1_type       <= SH_LSL;
            s1_eff        <= '0;
            s1_special    <= SP_NONE;
            s2_valid      <= 1'b0;
            bus_B         <= '0;
            shifter_carry <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid   <= 1'b1;
                s1_op      <= operand;
                s1_carry   <= carry_in;
                s1_type    <= shift_type;
                s1_eff     <= n_eff;
                s1_special <= n_special;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    bus_B         <= res;
                    shifter_carry <= cout;
                end
            end
        end
    end

endmodule
